sprite_row_fetcher: RTL and testbench
=====================================

SPRITE_ROW_FETCHER -- requirements
Module: sprite_row_fetcher

Interface
REQ-001 SHALL have parameter AddrBits, default 16, the RAM address width.
REQ-002 SHALL have parameter TileBase, default 8192, the byte address of tile 0.
REQ-003 SHALL have clk, input, 1, the single clock; every register updates on its rising edge.
REQ-004 SHALL have reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have start, input, 1, request to fetch one tile row.
REQ-006 SHALL have tileIndex, input, 8, tile number; each tile is 32 bytes (8 rows x 4 bytes, 4 bits per pixel).
REQ-007 SHALL have row, input, 3, row within the tile.
REQ-008 SHALL have ramAddress, output, AddrBits, address driven to the RAM.
REQ-009 SHALL have ramWriteEnabled, output, 1, RAM write strobe, constant 0.
REQ-010 SHALL have ramData, input, 8, RAM read data; combinational from ramAddress within the same cycle.
REQ-011 SHALL have busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have pixel, output, 4, current pixel colour index.
REQ-013 SHALL have pixelValid, output, 1, pixel is valid.
REQ-014 SHALL have pixelReady, input, 1, consumer accepts the pixel.
REQ-015 SHALL have lastPixel, output, 1, high while pixel 7 of the row is presented.
REQ-016 SHALL have done, output, 1, one-cycle pulse after the row completes.

Function
REQ-017 SHALL implement the states IDLE, FETCH, EMIT and DONE.
REQ-018 In IDLE, start=1 SHALL latch tileIndex and row, clear the byte counter to 0 and enter FETCH on the same edge.
REQ-019 In FETCH, ramAddress SHALL equal TileBase + tileIndex*32 + row*4 + byteCount, computed modulo 2^AddrBits (wrap-around, no error).
REQ-020 In FETCH, each cycle SHALL capture ramData into row-buffer byte byteCount and increment byteCount; after byte 3 the state SHALL move to EMIT with pixelCount=0.
REQ-021 FETCH SHALL last exactly 4 cycles; pixelValid SHALL rise in the 5th cycle after the start edge.
REQ-022 Pixel order SHALL be: pixel 2k is the high nibble of byte k, pixel 2k+1 is the low nibble of byte k (k=0..3).
REQ-023 In EMIT, pixelValid SHALL be 1, and pixel SHALL hold stable until a cycle where pixelValid and pixelReady are both 1; pixelCount SHALL increment on that edge.
REQ-024 Acceptance of pixel 7 SHALL move the state to DONE; done SHALL be 1 for exactly that one cycle, after which the state SHALL return to IDLE.
REQ-025 start SHALL be ignored in every state except IDLE, including DONE; a start held high SHALL begin a new fetch on the first IDLE cycle.
REQ-026 While not in FETCH, ramAddress SHALL be 0.
REQ-027 pixelValid, lastPixel and done SHALL be 0 outside their respective states.
REQ-028 pixelReady asserted while pixelValid=0 SHALL have no effect.

Reset
REQ-029 reset=0 SHALL immediately, without a clock edge, force the state to IDLE.
REQ-030 reset=0 SHALL clear the counters, row buffer, latched tileIndex and latched row to 0.
REQ-031 reset=0 SHALL drive busy, pixelValid, lastPixel, done, pixel and ramAddress to 0.
REQ-032 A reset asserted during FETCH or EMIT SHALL abort the row; no done pulse SHALL be produced for it.
REQ-033 Normal operation SHALL resume on the first rising clk edge after reset deasserts.

Verification
REQ-034 Bytes 0x01,0x10,0x01,0x10 at 8192..8195; tileIndex=0, row=0, pixelReady=1 -> pixels 0,1,1,0,0,1,1,0 on 8 consecutive cycles; lastPixel on the 8th; done on the next cycle.
REQ-035 Bytes 0x77,0x11,0x11,0x11 at 8196..8199; tileIndex=0, row=1 -> ramAddress 8196,8197,8198,8199 during FETCH; pixels 7,7,1,1,1,1,1,1.
REQ-036 Backpressure: pixelReady low for 3 cycles while pixel 2 is presented -> pixel and pixelValid stay stable; no pixel is skipped or duplicated; total 11 EMIT cycles.
REQ-037 TileBase=0xF000, tileIndex=255, row=7 -> ramAddress 0x0FFC..0x0FFF (wrapped modulo 2^16).
REQ-038 Reset pulsed low at pixel 4 -> outputs are 0 immediately, no done pulse occurs, and a new start after release fetches normally.
REQ-039 start pulsed during EMIT and during DONE -> ignored; exactly one done pulse; busy=0 afterwards.

Source files
------------

// File: rtl/sprite_row_fetcher.sv
// -----------------------------------------------------------------------------
// sprite_row_fetcher
//   Fetches one 4-byte row of a 4bpp 8x8 tile from a combinational-read RAM
//   and streams its eight pixels out over a valid/ready handshake.
//
//   Flow: IDLE -> FETCH (4 cycles, one byte each) -> EMIT (8 accepted pixels)
//         -> DONE (one cycle) -> IDLE.
//
// Parameters
//   AddrBits   RAM address width
//   TileBase   byte address of tile 0 (tile = 32 bytes, row = 4 bytes)
//
// Ports
//   clk              single clock, rising edge
//   reset            asynchronous active-low reset
//   start            request a row fetch (only honoured in IDLE)
//   tileIndex, row   tile number and row within the tile
//   ramAddress       RAM address (0 outside FETCH)
//   ramWriteEnabled  RAM write strobe, tied low
//   ramData          RAM read data, combinational from ramAddress
//   busy             high in every state except IDLE
//   pixel            current 4-bit colour index
//   pixelValid       pixel is valid (EMIT only)
//   pixelReady       consumer accepts the pixel
//   lastPixel        high while pixel 7 is presented
//   done             one-cycle pulse after the row completes
// -----------------------------------------------------------------------------
module sprite_row_fetcher #(
  parameter int AddrBits = 16,
  parameter int TileBase = 8192
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          tileIndex,
  input  logic [2:0]          row,
  output logic [AddrBits-1:0] ramAddress,
  output logic                ramWriteEnabled,
  input  logic [7:0]          ramData,
  output logic                busy,
  output logic [3:0]          pixel,
  output logic                pixelValid,
  input  logic                pixelReady,
  output logic                lastPixel,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Byte address of one row byte, wrapping modulo 2^AddrBits.
  function automatic logic [AddrBits-1:0] row_byte_address(
    input logic [7:0] tile,
    input logic [2:0] tile_row,
    input logic [1:0] byte_index
  );
    logic [31:0] sum_v;
    sum_v = 32'(TileBase)
          + {19'd0, tile, 5'd0}
          + {27'd0, tile_row, 2'd0}
          + {30'd0, byte_index};
    return sum_v[AddrBits-1:0];
  endfunction

  // Pixel 2k is the high nibble of byte k, pixel 2k+1 the low nibble.
  function automatic logic [3:0] select_nibble(
    input logic [3:0][7:0] row_buf,
    input logic [2:0]      pixel_index
  );
    logic [7:0] byte_v;
    byte_v = row_buf[pixel_index[2:1]];
    return pixel_index[0] ? byte_v[3:0] : byte_v[7:4];
  endfunction

  state_t               state_r;
  state_t               state_s;
  logic [1:0]           byte_count_r;
  logic [1:0]           byte_count_s;
  logic [2:0]           pixel_count_r;
  logic [2:0]           pixel_count_s;
  logic [7:0]           tile_r;
  logic [7:0]           tile_s;
  logic [2:0]           row_r;
  logic [2:0]           row_s;
  logic [3:0][7:0]      row_buf_r;
  logic [3:0][7:0]      row_buf_s;

  logic [AddrBits-1:0]  ram_address_r;
  logic [AddrBits-1:0]  ram_address_s;
  logic                 busy_r;
  logic [3:0]           pixel_r;
  logic [3:0]           pixel_s;
  logic                 pixel_valid_r;
  logic                 last_pixel_r;
  logic                 last_pixel_s;
  logic                 done_r;
  logic                 accept_s;

  assign accept_s = pixel_valid_r & pixelReady;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_s       = state_r;
    byte_count_s  = byte_count_r;
    pixel_count_s = pixel_count_r;
    tile_s        = tile_r;
    row_s         = row_r;
    row_buf_s     = row_buf_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          tile_s       = tileIndex;
          row_s        = row;
          byte_count_s = 2'd0;
          state_s      = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        row_buf_s[byte_count_r] = ramData;
        if (byte_count_r == 2'd3) begin
          byte_count_s  = 2'd0;
          pixel_count_s = 3'd0;
          state_s       = EMIT;
        end else begin
          byte_count_s = byte_count_r + 2'd1;
        end
      end
      EMIT: begin
        if (accept_s) begin
          if (pixel_count_r == 3'd7) begin
            state_s = DONE;
          end else begin
            pixel_count_s = pixel_count_r + 3'd1;
          end
        end else begin
          state_s = EMIT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so the
  // outputs can be registered without adding latency.
  always_comb begin
    ram_address_s = '0;
    pixel_s       = 4'd0;
    last_pixel_s  = 1'b0;
    if (state_s == FETCH) begin
      ram_address_s = row_byte_address(tile_s, row_s, byte_count_s);
    end else begin
      ram_address_s = '0;
    end
    if (state_s == EMIT) begin
      pixel_s      = select_nibble(row_buf_s, pixel_count_s);
      last_pixel_s = (pixel_count_s == 3'd7);
    end else begin
      pixel_s      = 4'd0;
      last_pixel_s = 1'b0;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_count_r  <= 2'd0;
      pixel_count_r <= 3'd0;
      tile_r        <= 8'd0;
      row_r         <= 3'd0;
      row_buf_r     <= '0;
      ram_address_r <= '0;
      busy_r        <= 1'b0;
      pixel_r       <= 4'd0;
      pixel_valid_r <= 1'b0;
      last_pixel_r  <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      byte_count_r  <= byte_count_s;
      pixel_count_r <= pixel_count_s;
      tile_r        <= tile_s;
      row_r         <= row_s;
      row_buf_r     <= row_buf_s;
      ram_address_r <= ram_address_s;
      busy_r        <= (state_s != IDLE);
      pixel_r       <= pixel_s;
      pixel_valid_r <= (state_s == EMIT);
      last_pixel_r  <= last_pixel_s;
      done_r        <= (state_s == DONE);
    end
  end

  assign ramAddress      = ram_address_r;
  assign ramWriteEnabled = 1'b0;
  assign busy            = busy_r;
  assign pixel           = pixel_r;
  assign pixelValid      = pixel_valid_r;
  assign lastPixel       = last_pixel_r;
  assign done            = done_r;

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// -----------------------------------------------------------------------------
// tb_sprite_row_fetcher
//   Directed bench for sprite_row_fetcher. A second instance with
//   TileBase=0xF000 exercises address wrap-around.
// -----------------------------------------------------------------------------
module tb_sprite_row_fetcher;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  tileIndex;
  logic [2:0]  row;
  logic [15:0] ramAddress;
  logic        ramWriteEnabled;
  logic [7:0]  ramData;
  logic        busy;
  logic [3:0]  pixel;
  logic        pixelValid;
  logic        pixelReady;
  logic        lastPixel;
  logic        done;

  logic        start2;
  logic [15:0] ramAddress2;
  logic        ramWriteEnabled2;
  logic [7:0]  ramData2;
  logic        busy2;
  logic [3:0]  pixel2;
  logic        pixelValid2;
  logic        lastPixel2;
  logic        done2;

  logic [7:0]  mem [65536];

  int checks;
  int errors;

  assign ramData  = mem[ramAddress];
  assign ramData2 = mem[ramAddress2];

  sprite_row_fetcher #(.AddrBits(16), .TileBase(8192)) dut (
    .clk(clk), .reset(reset), .start(start), .tileIndex(tileIndex), .row(row),
    .ramAddress(ramAddress), .ramWriteEnabled(ramWriteEnabled), .ramData(ramData),
    .busy(busy), .pixel(pixel), .pixelValid(pixelValid), .pixelReady(pixelReady),
    .lastPixel(lastPixel), .done(done)
  );

  sprite_row_fetcher #(.AddrBits(16), .TileBase(32'hF000)) dut_wrap (
    .clk(clk), .reset(reset), .start(start2), .tileIndex(8'd255), .row(3'd7),
    .ramAddress(ramAddress2), .ramWriteEnabled(ramWriteEnabled2), .ramData(ramData2),
    .busy(busy2), .pixel(pixel2), .pixelValid(pixelValid2), .pixelReady(1'b1),
    .lastPixel(lastPixel2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a fetch of tile 0 / row r with pixelReady held high and check the
  // whole transaction. pix holds pixel i in bits [31-4i -: 4].
  task automatic run_row(input logic [2:0] r, input logic [15:0] a0, input logic [31:0] pix);
    start     = 1'b1;
    tileIndex = 8'd0;
    row       = r;
    step();
    start     = 1'b0;
    for (int b = 0; b < 4; b++) begin
      check("fetch_busy", busy, 32'd1);
      check("fetch_addr", ramAddress, a0 + 16'(b));
      check("fetch_valid", pixelValid, 32'd0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      check("emit_valid", pixelValid, 32'd1);
      check("emit_pixel", pixel, pix[31-4*i -: 4]);
      check("emit_last", lastPixel, (i == 7) ? 32'd1 : 32'd0);
      check("emit_addr", ramAddress, 32'd0);
      step();
    end
    check("done_pulse", done, 32'd1);
    check("done_valid", pixelValid, 32'd0);
    check("done_busy", busy, 32'd1);
    step();
    check("done_clear", done, 32'd0);
    check("idle_busy", busy, 32'd0);
  endtask

  initial begin
    int idx;
    int cyc;
    int done_count;
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    start      = 1'b0;
    start2     = 1'b0;
    tileIndex  = 8'd0;
    row        = 3'd0;
    pixelReady = 1'b1;
    for (int a = 0; a < 65536; a++) mem[a] = 8'd0;
    mem[8192] = 8'h01; mem[8193] = 8'h10; mem[8194] = 8'h01; mem[8195] = 8'h10;
    mem[8196] = 8'h77; mem[8197] = 8'h11; mem[8198] = 8'h11; mem[8199] = 8'h11;
    mem[16'h0FFC] = 8'hA5; mem[16'h0FFD] = 8'h5A; mem[16'h0FFE] = 8'hC3; mem[16'h0FFF] = 8'h3C;

    // Reset state
    step();
    step();
    check("rst_busy", busy, 32'd0);
    check("rst_valid", pixelValid, 32'd0);
    check("rst_pixel", pixel, 32'd0);
    check("rst_addr", ramAddress, 32'd0);
    check("rst_last", lastPixel, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_we", ramWriteEnabled, 32'd0);
    reset = 1'b1;
    step();
    check("idle_busy0", busy, 32'd0);

    // Row 0: pixels 0,1,1,0,0,1,1,0
    run_row(3'd0, 16'd8192, 32'h01100110);
    // Row 1: pixels 7,7,1,1,1,1,1,1
    run_row(3'd1, 16'd8196, 32'h77111111);

    // Backpressure: ready low for 3 cycles while pixel 2 is shown
    start = 1'b1; tileIndex = 8'd0; row = 3'd0;
    step();
    start = 1'b0;
    for (int b = 0; b < 4; b++) step();
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 20) begin
      check("bp_valid", pixelValid, 32'd1);
      check("bp_pixel", pixel, 32'h01100110 >> (28 - 4 * idx) & 32'hF);
      pixelReady = (cyc < 2 || cyc > 4) ? 1'b1 : 1'b0;
      if (pixelReady) idx++;
      cyc++;
      step();
    end
    pixelReady = 1'b1;
    check("bp_emit_cycles", cyc, 32'd11);
    check("bp_done", done, 32'd1);
    step();
    check("bp_idle", busy, 32'd0);

    // Wrap-around: TileBase 0xF000, tile 255, row 7
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      check("wrap_addr", ramAddress2, 32'h0FFC + b);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      check("wrap_valid", pixelValid2, 32'd1);
      check("wrap_pixel", pixel2, 32'hA55AC33C >> (28 - 4 * i) & 32'hF);
      step();
    end
    check("wrap_done", done2, 32'd1);
    step();
    check("wrap_idle", busy2, 32'd0);

    // Asynchronous reset while pixel 4 is presented
    start = 1'b1; tileIndex = 8'd0; row = 3'd0;
    step();
    start = 1'b0;
    for (int b = 0; b < 4; b++) step();
    for (int i = 0; i < 4; i++) step();
    check("ar_pix4_valid", pixelValid, 32'd1);
    check("ar_pix4_idx", lastPixel, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("ar_busy", busy, 32'd0);
    check("ar_valid", pixelValid, 32'd0);
    check("ar_pixel", pixel, 32'd0);
    check("ar_addr", ramAddress, 32'd0);
    check("ar_done", done, 32'd0);
    step();
    check("ar_done_held", done, 32'd0);
    reset = 1'b1;
    done_count = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) done_count++;
      step();
    end
    check("ar_no_done", done_count, 32'd0);
    check("ar_idle", busy, 32'd0);
    run_row(3'd1, 16'd8196, 32'h77111111);

    // start during EMIT and DONE is ignored
    start = 1'b1; tileIndex = 8'd0; row = 3'd0;
    step();
    start = 1'b0;
    for (int b = 0; b < 4; b++) step();
    done_count = 0;
    for (int i = 0; i < 8; i++) begin
      start = (i == 3) ? 1'b1 : 1'b0;
      check("ig_pixel", pixel, 32'h01100110 >> (28 - 4 * i) & 32'hF);
      step();
    end
    start = 1'b1;
    check("ig_done", done, 32'd1);
    if (done) done_count++;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_count++;
      check("ig_busy", busy, 32'd0);
      step();
    end
    check("ig_one_done", done_count, 32'd1);
    check("ig_addr", ramAddress, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
